m68k_bus_arbiter: RTL and testbench

M68K_BUS_ARBITER -- requirements
Module: m68k_bus_arbiter

---
 rtl/m68k_bus_arbiter_pkg.sv | 21 ++
 rtl/m68k_bus_arbiter_if.sv | 25 ++
 rtl/m68k_bus_arbiter_sync_edge.sv | 25 ++
 rtl/m68k_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_m68k_bus_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/m68k_bus_arbiter_pkg.sv
// Shared definitions for the PiStorm 68k bus arbiter: FSM encoding,
// default timing constants and a counter sizing helper.
package pistorm_pkg;

    typedef enum logic [2:0] {
        ST_LOCAL   = 3'd0,
        ST_BR_PEND = 3'd1,
        ST_GRANT   = 3'd2,
        ST_EXT     = 3'd3,
        ST_SETTLE  = 3'd4
    } arb_state_t;

    localparam int DEF_GRANT_TIMEOUT = 15;
    localparam int DEF_SETTLE_CYCLES = 1;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/m68k_bus_arbiter_if.sv
// 68k bus arbitration signals between the arbiter and the rest of the
// system (external master pins and the local bus sequencer).
interface m68k_bus_arbiter_if;
    logic M68K_CLK;
    logic M68K_BR_n;
    logic M68K_BGACK_n;
    logic local_req;
    logic local_busy;
    logic M68K_BG_n;
    logic local_grant;
    logic bus_release;
    logic grant_timeout;

    // Arbiter side.
    modport master (
        input  M68K_CLK, M68K_BR_n, M68K_BGACK_n, local_req, local_busy,
        output M68K_BG_n, local_grant, bus_release, grant_timeout
    );

    // Bus / sequencer side.
    modport slave (
        output M68K_CLK, M68K_BR_n, M68K_BGACK_n, local_req, local_busy,
        input  M68K_BG_n, local_grant, bus_release, grant_timeout
    );
endinterface

// File: rtl/m68k_bus_arbiter_sync_edge.sv
// N-flop synchronizer with rise/fall detection on the synchronized level.
// stage[0] is the first flop, stage[N-1] the oldest sample.
module sync_edge #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [N-1:0] stage;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stage <= {N{RST_VAL}};
        else     stage <= {stage[N-2:0], d};
    end

    assign q    = stage[N-1];
    assign rise = ~stage[N-1] &  stage[N-2];
    assign fall =  stage[N-1] & ~stage[N-2];
endmodule

// File: rtl/m68k_bus_arbiter.sv
// 68000 bus arbiter: hands the bus to an external master on BR_n/BG_n/BGACK_n
// and returns it to the local sequencer. All decisions are taken on falling
// edges of the (oversampled) 7 MHz bus clock.
module m68k_bus_arbiter
    import pistorm_pkg::*;
#(
    parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input logic               PI_CLK,
    input logic               RST,
    m68k_bus_arbiter_if.master bus
);
    localparam int CW = cnt_width(GRANT_TIMEOUT);
    localparam int SW = cnt_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] TO_MAX = CW'(GRANT_TIMEOUT);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] grant_cnt, grant_cnt_nxt;
    logic [SW-1:0] settle_cnt, settle_cnt_nxt;
    logic          timeout_evt, timeout_q;
    logic          bg_n, local_grant, bus_release;

    logic c7m_fall, c7m_level_unused, c7m_rise_unused;
    logic br_n_s, br_rise_unused, br_fall_unused;
    logic bgack_n_s, bgack_rise_unused, bgack_fall_unused;

    sync_edge #(.N(3), .RST_VAL(1'b1)) u_sync_c7m (
        .clk(PI_CLK), .rst(RST), .d(bus.M68K_CLK),
        .q(c7m_level_unused), .rise(c7m_rise_unused), .fall(c7m_fall)
    );

    sync_edge #(.N(2), .RST_VAL(1'b1)) u_sync_br (
        .clk(PI_CLK), .rst(RST), .d(bus.M68K_BR_n),
        .q(br_n_s), .rise(br_rise_unused), .fall(br_fall_unused)
    );

    sync_edge #(.N(2), .RST_VAL(1'b1)) u_sync_bgack (
        .clk(PI_CLK), .rst(RST), .d(bus.M68K_BGACK_n),
        .q(bgack_n_s), .rise(bgack_rise_unused), .fall(bgack_fall_unused)
    );

    // State and counters advance only on bus-clock falling edges; the
    // timeout flag is a single PI_CLK pulse.
    always_ff @(posedge PI_CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_LOCAL;
            grant_cnt  <= '0;
            settle_cnt <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= timeout_evt;
            if (c7m_fall) begin
                state      <= state_nxt;
                grant_cnt  <= grant_cnt_nxt;
                settle_cnt <= settle_cnt_nxt;
            end
        end
    end

    // Next-state, counter and output decode. Counters clear whenever their
    // state is not active, so entry to GRANT/SETTLE always starts at zero.
    always_comb begin
        state_nxt      = state;
        grant_cnt_nxt  = '0;
        settle_cnt_nxt = '0;
        timeout_evt    = 1'b0;
        bg_n           = 1'b1;
        local_grant    = 1'b0;
        bus_release    = 1'b0;
        case (state)
            ST_LOCAL: begin
                // A pending external request beats a local request that has
                // not started yet.
                local_grant = ~(bus.local_req & ~br_n_s);
                if (~bgack_n_s & ~bus.local_busy)
                    state_nxt = ST_EXT;
                else if (~br_n_s | ~bgack_n_s)
                    state_nxt = ST_BR_PEND;
            end
            ST_BR_PEND: begin
                // Wait for the running local cycle to finish.
                if (~bgack_n_s & ~bus.local_busy)
                    state_nxt = ST_EXT;
                else if (br_n_s & bgack_n_s)
                    state_nxt = ST_LOCAL;
                else if (~bus.local_busy)
                    state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                bg_n          = 1'b0;
                bus_release   = 1'b1;
                grant_cnt_nxt = (grant_cnt == TO_MAX) ? grant_cnt : grant_cnt + 1'b1;
                if (~bgack_n_s)
                    state_nxt = ST_EXT;
                else if (br_n_s)
                    state_nxt = ST_SETTLE;
                else if (int'(grant_cnt) + 1 >= GRANT_TIMEOUT) begin
                    state_nxt   = ST_SETTLE;
                    timeout_evt = c7m_fall;
                end
            end
            ST_EXT: begin
                // BR_n is ignored while the external master holds BGACK_n.
                bus_release = 1'b1;
                if (bgack_n_s)
                    state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                bus_release    = 1'b1;
                settle_cnt_nxt = settle_cnt + 1'b1;
                if (int'(settle_cnt) + 1 >= SETTLE_CYCLES)
                    state_nxt = br_n_s ? ST_LOCAL : ST_BR_PEND;
            end
            default: state_nxt = ST_LOCAL;
        endcase
    end

    assign bus.M68K_BG_n     = bg_n;
    assign bus.local_grant   = local_grant;
    assign bus.bus_release   = bus_release;
    assign bus.grant_timeout = timeout_q;
endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed bench for m68k_bus_arbiter: walks the arbitration handshake,
// busy deferral, grant timeout, withdrawn requests and asynchronous reset.
`timescale 1ns/1ps
module tb_m68k_bus_arbiter;

    logic PI_CLK = 1'b0;
    logic RST    = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   to_cycles = 0;

    m68k_bus_arbiter_if bus();

    m68k_bus_arbiter #(.GRANT_TIMEOUT(15), .SETTLE_CYCLES(1)) dut (
        .PI_CLK(PI_CLK),
        .RST(RST),
        .bus(bus)
    );

    // 200 MHz system clock.
    always #2.5 PI_CLK = ~PI_CLK;

    // ~7 MHz bus clock, asynchronous to PI_CLK edges.
    initial begin
        bus.M68K_CLK = 1'b1;
        forever #70 bus.M68K_CLK = ~bus.M68K_CLK;
    end

    // Count PI_CLK cycles during which grant_timeout is high.
    always @(negedge PI_CLK) if (bus.grant_timeout === 1'b1) to_cycles++;

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for one bus-clock fall plus synchronizer latency, then settle on
    // a PI_CLK falling edge where outputs are sampled and inputs driven.
    task automatic fall_step();
        @(negedge bus.M68K_CLK);
        repeat (5) @(posedge PI_CLK);
        @(negedge PI_CLK);
    endtask

    initial begin
        bus.M68K_BR_n    = 1'b1;
        bus.M68K_BGACK_n = 1'b1;
        bus.local_req    = 1'b0;
        bus.local_busy   = 1'b0;

        // Reset values, before any clock edge.
        #1 RST = 1'b1;
        #1;
        check("rst_bg_n", bus.M68K_BG_n, 1);
        check("rst_local_grant", bus.local_grant, 1);
        check("rst_bus_release", bus.bus_release, 0);
        check("rst_timeout", bus.grant_timeout, 0);
        repeat (4) @(negedge PI_CLK);
        RST = 1'b0;
        fall_step();
        check("idle_local_grant", bus.local_grant, 1);
        check("idle_bus_release", bus.bus_release, 0);

        // Full handshake: request, grant after two falls, acknowledge, release.
        bus.M68K_BR_n = 1'b0;
        fall_step();
        check("hs_pend_bg_n", bus.M68K_BG_n, 1);
        check("hs_pend_local_grant", bus.local_grant, 0);
        fall_step();
        check("hs_grant_bg_n", bus.M68K_BG_n, 0);
        check("hs_grant_release", bus.bus_release, 1);
        bus.M68K_BGACK_n = 1'b0;
        fall_step();
        check("hs_ext_bg_n", bus.M68K_BG_n, 1);
        check("hs_ext_release", bus.bus_release, 1);
        check("hs_ext_local_grant", bus.local_grant, 0);
        // New request while BGACK_n still low is ignored.
        bus.M68K_BR_n = 1'b1;
        fall_step();
        bus.M68K_BR_n = 1'b0;
        fall_step();
        check("hs_ext_rereq_bg_n", bus.M68K_BG_n, 1);
        check("hs_ext_rereq_release", bus.bus_release, 1);
        bus.M68K_BR_n    = 1'b1;
        bus.M68K_BGACK_n = 1'b1;
        fall_step();
        check("hs_settle_release", bus.bus_release, 1);
        check("hs_settle_local_grant", bus.local_grant, 0);
        fall_step();
        check("hs_back_local_grant", bus.local_grant, 1);
        check("hs_back_release", bus.bus_release, 0);
        check("hs_back_bg_n", bus.M68K_BG_n, 1);

        // Request during a busy local cycle: grant waits for local_busy=0.
        bus.local_busy = 1'b1;
        bus.M68K_BR_n  = 1'b0;
        fall_step();
        check("busy_pend_local_grant", bus.local_grant, 0);
        for (int i = 0; i < 4; i++) begin
            fall_step();
            check($sformatf("busy_wait%0d_bg_n", i), bus.M68K_BG_n, 1);
            check($sformatf("busy_wait%0d_local_grant", i), bus.local_grant, 0);
        end
        bus.local_busy = 1'b0;
        fall_step();
        check("busy_grant_bg_n", bus.M68K_BG_n, 0);
        // Request withdrawn before acknowledge: no timeout, bus reclaimed.
        bus.M68K_BR_n = 1'b1;
        fall_step();
        check("wd_settle_bg_n", bus.M68K_BG_n, 1);
        check("wd_settle_release", bus.bus_release, 1);
        check("wd_no_timeout", to_cycles, 0);
        fall_step();
        check("wd_local_grant", bus.local_grant, 1);

        // Request dropped while still pending (busy): straight back to local.
        bus.local_busy = 1'b1;
        bus.M68K_BR_n  = 1'b0;
        fall_step();
        check("drop_pend_local_grant", bus.local_grant, 0);
        bus.M68K_BR_n = 1'b1;
        fall_step();
        check("drop_local_grant", bus.local_grant, 1);
        check("drop_bg_n", bus.M68K_BG_n, 1);
        bus.local_busy = 1'b0;

        // No acknowledge: grant held 15 bus cycles, then withdrawn.
        bus.M68K_BR_n = 1'b0;
        fall_step();
        fall_step();
        check("to_grant_bg_n", bus.M68K_BG_n, 0);
        repeat (14) fall_step();
        check("to_cycle14_bg_n", bus.M68K_BG_n, 0);
        check("to_cycle14_no_pulse", to_cycles, 0);
        fall_step();
        check("to_withdrawn_bg_n", bus.M68K_BG_n, 1);
        check("to_settle_release", bus.bus_release, 1);
        check("to_pulse_one_cycle", to_cycles, 1);
        // BR_n still low at settle exit: re-arbitrate rather than go local.
        fall_step();
        check("to_repend_local_grant", bus.local_grant, 0);
        check("to_repend_bg_n", bus.M68K_BG_n, 1);
        fall_step();
        check("to_regrant_bg_n", bus.M68K_BG_n, 0);
        bus.M68K_BR_n = 1'b1;
        fall_step();
        fall_step();
        check("to_back_local_grant", bus.local_grant, 1);
        check("to_pulse_total", to_cycles, 1);

        // Local request and external request together: external wins.
        bus.local_req = 1'b1;
        bus.M68K_BR_n = 1'b0;
        fall_step();
        check("sim_pend_local_grant", bus.local_grant, 0);
        fall_step();
        check("sim_grant_bg_n", bus.M68K_BG_n, 0);
        check("sim_grant_local_grant", bus.local_grant, 0);
        bus.M68K_BGACK_n = 1'b0;
        fall_step();
        check("sim_ext_local_grant", bus.local_grant, 0);
        bus.M68K_BR_n    = 1'b1;
        bus.M68K_BGACK_n = 1'b1;
        fall_step();
        check("sim_settle_local_grant", bus.local_grant, 0);
        fall_step();
        check("sim_back_local_grant", bus.local_grant, 1);
        bus.local_req = 1'b0;

        // BGACK_n without any request: bus taken over directly.
        bus.M68K_BGACK_n = 1'b0;
        fall_step();
        check("rogue_ext_bg_n", bus.M68K_BG_n, 1);
        check("rogue_ext_release", bus.bus_release, 1);
        check("rogue_ext_local_grant", bus.local_grant, 0);
        bus.M68K_BGACK_n = 1'b1;
        fall_step();
        fall_step();
        check("rogue_back_local_grant", bus.local_grant, 1);

        // Reset during GRANT negates BG_n immediately.
        bus.M68K_BR_n = 1'b0;
        fall_step();
        fall_step();
        check("rg_grant_bg_n", bus.M68K_BG_n, 0);
        RST = 1'b1;
        #1;
        check("rg_bg_n", bus.M68K_BG_n, 1);
        check("rg_release", bus.bus_release, 0);
        check("rg_local_grant", bus.local_grant, 1);
        @(negedge PI_CLK);
        RST = 1'b0;

        // Reset during EXT: bus reclaimed at once, before any clock edge.
        fall_step();
        fall_step();
        bus.M68K_BGACK_n = 1'b0;
        fall_step();
        check("re_ext_release", bus.bus_release, 1);
        RST = 1'b1;
        #1;
        check("re_bg_n", bus.M68K_BG_n, 1);
        check("re_local_grant", bus.local_grant, 1);
        check("re_release", bus.bus_release, 0);
        check("re_timeout", bus.grant_timeout, 0);
        bus.M68K_BR_n    = 1'b1;
        bus.M68K_BGACK_n = 1'b1;
        @(negedge PI_CLK);
        RST = 1'b0;
        fall_step();
        check("re_after_local_grant", bus.local_grant, 1);
        check("re_after_release", bus.bus_release, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
